// File: rtl/cache_mem_arbiter_pkg.sv
// Shared cache<->memory types plus the arbiter state encoding.
package cache_def;

  parameter int ADDR_W    = 32;
  parameter int DATA_W    = 128;
  parameter int ARB_PORTS = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              rw;
    logic              valid;
  } mem_req_type;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              ready;
  } mem_data_type;

  typedef enum logic [1:0] {ARB_IDLE, ARB_GNT0, ARB_GNT1} arb_state_type;

endpackage

// File: rtl/cache_mem_arbiter_rr_arb2.sv
// Two-way round-robin pick: one-hot winner, rr_ptr breaks ties (0 -> port 0).
module rr_arb2 (
  input  logic       i_valid0,
  input  logic       i_valid1,
  input  logic       i_rr_ptr,
  output logic [1:0] o_winner
);

  always_comb begin
    o_winner = 2'b00;
    if (i_valid0 && i_valid1) o_winner = i_rr_ptr ? 2'b10 : 2'b01;
    else if (i_valid0)        o_winner = 2'b01;
    else if (i_valid1)        o_winner = 2'b10;
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one memory port between the I-cache (port 0) and D-cache (port 1),
// holding each grant until memory answers, with a sticky no-response watchdog.
module cache_mem_arbiter
  import cache_def::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  mem_req_type          req0,
  output mem_data_type         rsp0,
  input  mem_req_type          req1,
  output mem_data_type         rsp1,
  output mem_req_type          mem_req,
  input  mem_data_type         mem_rsp,
  output logic [ARB_PORTS-1:0] grant,
  output logic                 err_timeout
);

  localparam logic [CNT_W-1:0] LP_TMO = CNT_W'(TIMEOUT_CYCLES);

  arb_state_type    r_state, w_next;
  logic             r_rr_ptr, w_rr_ptr_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic [1:0]       w_win;
  logic             w_stall;

  rr_arb2 u_rr (
    .i_valid0 (req0.valid),
    .i_valid1 (req1.valid),
    .i_rr_ptr (r_rr_ptr),
    .o_winner (w_win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ARB_IDLE;
      r_rr_ptr <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  // A completed grant always returns to IDLE so a stale valid is never re-granted.
  always_comb begin
    w_next       = r_state;
    w_rr_ptr_nxt = r_rr_ptr;
    case (r_state)
      ARB_IDLE: begin
        if (w_win[0])      w_next = ARB_GNT0;
        else if (w_win[1]) w_next = ARB_GNT1;
      end
      ARB_GNT0: begin
        if (mem_rsp.ready) begin
          w_next       = ARB_IDLE;
          w_rr_ptr_nxt = 1'b1;
        end
      end
      ARB_GNT1: begin
        if (mem_rsp.ready) begin
          w_next       = ARB_IDLE;
          w_rr_ptr_nxt = 1'b0;
        end
      end
      default: w_next = ARB_IDLE;
    endcase
  end

  assign grant = {r_state == ARB_GNT1, r_state == ARB_GNT0};

  always_comb begin
    mem_req = '0;
    if (grant[0])      mem_req = req0;
    else if (grant[1]) mem_req = req1;
  end

  assign rsp0.data  = mem_rsp.data;
  assign rsp0.ready = mem_rsp.ready & grant[0];
  assign rsp1.data  = mem_rsp.data;
  assign rsp1.ready = mem_rsp.ready & grant[1];

  // Watchdog: counter is held at zero in IDLE, so every grant starts from zero.
  assign w_stall = (r_state != ARB_IDLE) && !mem_rsp.ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == ARB_IDLE)                r_cnt <= '0;
      else if (w_stall && r_cnt != LP_TMO)    r_cnt <= r_cnt + 1'b1;
      if (TIMEOUT_CYCLES != 0 && w_stall && r_cnt == LP_TMO - 1'b1)
        r_err <= 1'b1;
    end
  end

  assign err_timeout = r_err;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level model.
module tb_cache_mem_arbiter;
  import cache_def::*;

  localparam int TMO = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  mem_req_type  req0, req1, mem_req;
  mem_data_type rsp0, rsp1, mem_rsp;
  logic [1:0]   grant;
  logic         err_timeout;

  int checks   = 0;
  int failures = 0;

  logic [127:0] store [logic [31:0]];

  cache_mem_arbiter #(.TIMEOUT_CYCLES(TMO), .CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0        (req0),
    .rsp0        (rsp0),
    .req1        (req1),
    .rsp1        (rsp1),
    .mem_req     (mem_req),
    .mem_rsp     (mem_rsp),
    .grant       (grant),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    req0    = '0;
    req1    = '0;
    mem_rsp = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req0 = '0; req1 = '0; mem_rsp = '0;
    #3;
    checks++; if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b exp=00", grant); end
    checks++; if (mem_req !== '0) begin failures++; $display("FAIL reset_mem_req got=%h exp=0", mem_req); end
    checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_timeout); end
    req0.valid = 1'b1; mem_rsp.ready = 1'b1;
    @(posedge clk); @(posedge clk); #2;
    checks++; if (grant !== 2'b00) begin failures++; $display("FAIL reset_hold_grant got=%b exp=00", grant); end
    checks++; if (rsp0.ready !== 1'b0 || rsp1.ready !== 1'b0) begin failures++; $display("FAIL reset_rsp_ready got=%b%b exp=00", rsp1.ready, rsp0.ready); end
    req0 = '0; mem_rsp = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [127:0] d;
    d = {4{32'h1111_1111}};
    do_reset();
    req0 = '{addr: 32'h0000_4000, data: '0, rw: 1'b0, valid: 1'b1};
    #2;
    checks++; if (mem_req.valid !== 1'b0) begin failures++; $display("FAIL single_pre_grant_valid got=%b exp=0", mem_req.valid); end
    tick(); #1;
    checks++; if (grant !== 2'b01) begin failures++; $display("FAIL single_grant got=%b exp=01", grant); end
    checks++; if (mem_req.addr !== 32'h0000_4000 || mem_req.valid !== 1'b1 || mem_req.rw !== 1'b0)
      begin failures++; $display("FAIL single_mem_req got=%h/%b/%b exp=00004000/0/1", mem_req.addr, mem_req.rw, mem_req.valid); end
    tick(); #1;
    checks++; if (rsp0.ready !== 1'b0) begin failures++; $display("FAIL single_early_ready got=%b exp=0", rsp0.ready); end
    tick();
    mem_rsp = '{data: d, ready: 1'b1};
    #1;
    checks++; if (rsp0.ready !== 1'b1 || rsp0.data !== d) begin failures++; $display("FAIL single_rsp0 got=%b/%h exp=1/%h", rsp0.ready, rsp0.data, d); end
    checks++; if (rsp1.ready !== 1'b0) begin failures++; $display("FAIL single_rsp1 got=%b exp=0", rsp1.ready); end
    tick();
    req0 = '0; mem_rsp = '0;
    #1;
    checks++; if (grant !== 2'b00 || rsp0.ready !== 1'b0) begin failures++; $display("FAIL single_release got=%b/%b exp=00/0", grant, rsp0.ready); end
  endtask

  task automatic test_contention();
    logic [1:0] exp;
    do_reset();
    req0 = '{addr: 32'h100, data: '0, rw: 1'b0, valid: 1'b1};
    req1 = '{addr: 32'h200, data: '0, rw: 1'b0, valid: 1'b1};
    for (int i = 0; i < 4; i++) begin
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      tick(); #1;
      checks++; if (grant !== exp) begin failures++; $display("FAIL contention_grant%0d got=%b exp=%b", i, grant, exp); end
      mem_rsp = '{data: 128'(i + 5), ready: 1'b1};
      #1;
      checks++; if ({rsp1.ready, rsp0.ready} !== exp) begin failures++; $display("FAIL contention_ready%0d got=%b exp=%b", i, {rsp1.ready, rsp0.ready}, exp); end
      tick();
      mem_rsp = '0;
      #1;
      checks++; if (grant !== 2'b00) begin failures++; $display("FAIL contention_idle%0d got=%b exp=00", i, grant); end
    end
    req0 = '0; req1 = '0;
    tick();
  endtask

  task automatic test_write();
    mem_req_type w;
    w = '{addr: 32'h8000_0010, data: 128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF, rw: 1'b1, valid: 1'b1};
    req1 = w;
    tick(); #1;
    checks++; if (grant !== 2'b10) begin failures++; $display("FAIL write_grant got=%b exp=10", grant); end
    checks++; if (mem_req !== w) begin failures++; $display("FAIL write_mem_req got=%h exp=%h", mem_req, w); end
    checks++; if (rsp0.ready !== 1'b0) begin failures++; $display("FAIL write_rsp0_idle got=%b exp=0", rsp0.ready); end
    tick();
    mem_rsp = '{data: '0, ready: 1'b1};
    #1;
    checks++; if (rsp1.ready !== 1'b1 || rsp0.ready !== 1'b0) begin failures++; $display("FAIL write_done got=%b%b exp=10", rsp1.ready, rsp0.ready); end
    tick();
    req1 = '0; mem_rsp = '0;
  endtask

  task automatic test_spurious();
    mem_rsp = '{data: {4{32'hA5A5_5A5A}}, ready: 1'b1};
    #1;
    checks++; if (rsp0.ready !== 1'b0 || rsp1.ready !== 1'b0) begin failures++; $display("FAIL spurious_ready got=%b%b exp=00", rsp1.ready, rsp0.ready); end
    checks++; if (mem_req !== '0) begin failures++; $display("FAIL spurious_mem_req got=%h exp=0", mem_req); end
    tick(); #1;
    checks++; if (grant !== 2'b00) begin failures++; $display("FAIL spurious_grant got=%b exp=00", grant); end
    mem_rsp = '0;
    req0 = '{addr: 32'h300, data: '0, rw: 1'b0, valid: 1'b1};
    req1 = '{addr: 32'h400, data: '0, rw: 1'b0, valid: 1'b1};
    tick(); #1;
    checks++; if (grant !== 2'b01) begin failures++; $display("FAIL spurious_ptr got=%b exp=01", grant); end
    mem_rsp.ready = 1'b1;
    tick();
    req0 = '0; req1 = '0; mem_rsp = '0;
    tick();
  endtask

  task automatic test_timeout();
    req0 = '{addr: 32'h500, data: '0, rw: 1'b0, valid: 1'b1};
    tick(); #1;
    for (int c = 1; c <= 12; c++) begin
      checks++; if (grant !== 2'b01) begin failures++; $display("FAIL timeout_hold%0d got=%b exp=01", c, grant); end
      checks++; if (err_timeout !== (c > TMO)) begin failures++; $display("FAIL timeout_err%0d got=%b exp=%b", c, err_timeout, c > TMO); end
      tick(); #1;
    end
    mem_rsp = '{data: '0, ready: 1'b1};
    #1;
    checks++; if (rsp0.ready !== 1'b1) begin failures++; $display("FAIL timeout_late_ready got=%b exp=1", rsp0.ready); end
    tick();
    req0 = '0; mem_rsp = '0;
    req1 = '{addr: 32'h600, data: '0, rw: 1'b0, valid: 1'b1};
    tick(); #1;
    checks++; if (grant !== 2'b10) begin failures++; $display("FAIL timeout_next_grant got=%b exp=10", grant); end
    mem_rsp.ready = 1'b1;
    #1;
    checks++; if (rsp1.ready !== 1'b1) begin failures++; $display("FAIL timeout_next_ready got=%b exp=1", rsp1.ready); end
    tick();
    req1 = '0; mem_rsp = '0;
    #1;
    checks++; if (err_timeout !== 1'b1) begin failures++; $display("FAIL timeout_sticky got=%b exp=1", err_timeout); end
  endtask

  task automatic test_reset_mid();
    req1 = '{addr: 32'h700, data: '1, rw: 1'b1, valid: 1'b1};
    tick(); #1;
    checks++; if (grant !== 2'b10) begin failures++; $display("FAIL rstmid_grant got=%b exp=10", grant); end
    checks++; if (err_timeout !== 1'b1) begin failures++; $display("FAIL rstmid_err_before got=%b exp=1", err_timeout); end
    rst_n = 1'b0;
    mem_rsp.ready = 1'b1;
    #1;
    checks++; if (grant !== 2'b00 || mem_req.valid !== 1'b0) begin failures++; $display("FAIL rstmid_async got=%b/%b exp=00/0", grant, mem_req.valid); end
    checks++; if (err_timeout !== 1'b0 || rsp1.ready !== 1'b0) begin failures++; $display("FAIL rstmid_err got=%b/%b exp=0/0", err_timeout, rsp1.ready); end
    mem_rsp = '0;
    req0 = '{addr: 32'h800, data: '0, rw: 1'b0, valid: 1'b1};
    req1 = '{addr: 32'h900, data: '0, rw: 1'b0, valid: 1'b1};
    tick();
    rst_n = 1'b1;
    tick(); #1;
    checks++; if (grant !== 2'b01) begin failures++; $display("FAIL rstmid_first got=%b exp=01", grant); end
    mem_rsp.ready = 1'b1;
    tick();
    req0 = '0; req1 = '0; mem_rsp = '0;
    tick();
  endtask

  // Model: owner 0 = none, 1 = port 0, 2 = port 1; memory answers after 0..3 stall cycles.
  task automatic test_random();
    int           own, ptr, mlat;
    int           served [2];
    logic         pend [2];
    mem_req_type  preq [2];
    mem_req_type  cur, emr;
    logic         rdy;
    logic [127:0] rdata;
    logic [1:0]   eg;
    do_reset();
    own = 0; ptr = 0; mlat = 0;
    served[0] = 0; served[1] = 0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    preq[0] = '0; preq[1] = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) != 0) begin
          preq[p].addr  = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
          preq[p].data  = {$urandom, $urandom, $urandom, $urandom};
          preq[p].rw    = 1'($urandom_range(0, 1));
          preq[p].valid = 1'b1;
          pend[p] = 1'b1;
        end
      end
      req0 = pend[0] ? preq[0] : '0;
      req1 = pend[1] ? preq[1] : '0;
      rdy   = 1'b0;
      rdata = {$urandom, $urandom, $urandom, $urandom};
      if (own != 0) begin
        if (mlat == 0) begin
          rdy = 1'b1;
          cur = preq[own-1];
          if (!cur.rw) rdata = store.exists(cur.addr) ? store[cur.addr] : {4{cur.addr}};
        end
      end else if ($urandom_range(0, 7) == 0) begin
        rdy = 1'b1;
      end
      mem_rsp.data  = rdata;
      mem_rsp.ready = rdy;
      #1;
      eg  = (own == 1) ? 2'b01 : (own == 2) ? 2'b10 : 2'b00;
      emr = (own == 1) ? preq[0] : (own == 2) ? preq[1] : '0;
      checks++; if (grant !== eg) begin failures++; $display("FAIL rand_grant cyc=%0d got=%b exp=%b", cyc, grant, eg); end
      checks++; if (mem_req !== emr) begin failures++; $display("FAIL rand_mem_req cyc=%0d got=%h exp=%h", cyc, mem_req, emr); end
      checks++; if (rsp0.ready !== (rdy && own == 1) || rsp1.ready !== (rdy && own == 2))
        begin failures++; $display("FAIL rand_ready cyc=%0d got=%b%b exp=%b%b", cyc, rsp1.ready, rsp0.ready, rdy && own == 2, rdy && own == 1); end
      checks++; if (rsp0.data !== rdata || rsp1.data !== rdata) begin failures++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", cyc, rsp0.data, rdata); end
      checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL rand_err cyc=%0d got=%b exp=0", cyc, err_timeout); end
      if (own == 0) begin
        if (pend[0] && pend[1]) own = ptr + 1;
        else if (pend[0])       own = 1;
        else if (pend[1])       own = 2;
        if (own != 0) mlat = $urandom_range(0, 3);
      end else if (rdy) begin
        if (preq[own-1].rw) store[preq[own-1].addr] = preq[own-1].data;
        pend[own-1] = 1'b0;
        served[own-1]++;
        ptr = (own == 1) ? 1 : 0;
        own = 0;
      end else begin
        mlat--;
      end
      tick();
    end
    req0 = '0; req1 = '0; mem_rsp = '0;
    checks++; if (served[0] == 0 || served[1] == 0) begin failures++; $display("FAIL rand_coverage got=%0d/%0d exp=nonzero", served[0], served[1]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_write();
    test_spurious();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
